teclado_digitos: RTL and testbench

//  Front end of the lock's digit path. Scans a 4x4 matrix keypad and debounces it.

---
 rtl/teclado_digitos.sv | 167 ++++++++++++++++
 tb/tb_teclado_digitos.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/teclado_digitos.sv
// 4x4 keypad scanner/debouncer feeding a 20-digit buffer (senhaPac_t layout: digits[i] = bits [4i+3:4i], digits[0] newest).
// Optional idle discard of a partial buffer is enabled by defining KEYPAD_TIMEOUT_EN.
//
// state        | meaning
// SCAN         | rotate one-cold column drive, look for any row low
// DEBOUNCE     | column frozen, row pattern must stay stable DEBOUNCE_CYC cycles
// ACCEPT       | one cycle: shift code into buffer, digitos_valid high
// WAIT_RELEASE | column frozen, rows must read idle DEBOUNCE_CYC cycles
module teclado_digitos #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 10000,
  parameter int TIMEOUT_CYC  = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [79:0] digitos_value,
  output logic        digitos_valid
);

  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, ACCEPT, WAIT_RELEASE} state_t;

  state_t          state, state_nx;
  logic [3:0]      row_s1, row_s2, row_lat;
  logic [SW-1:0]   scan_cnt;
  logic [DW-1:0]   deb_cnt;
  logic            armed;
  logic [3:0]      code;
  logic            key_ok;
  logic            scan_settled, deb_done, rotate, is_term, idle_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  always_comb begin
    key_ok = 1'b1;
    code   = 4'hF;
    case ({row_lat, col})
      8'b1110_1110: code = 4'h1;
      8'b1110_1101: code = 4'h2;
      8'b1110_1011: code = 4'h3;
      8'b1101_1110: code = 4'h4;
      8'b1101_1101: code = 4'h5;
      8'b1101_1011: code = 4'h6;
      8'b1011_1110: code = 4'h7;
      8'b1011_1101: code = 4'h8;
      8'b1011_1011: code = 4'h9;
      8'b0111_1110: code = 4'hA;
      8'b0111_1101: code = 4'h0;
      8'b0111_1011: code = 4'hB;
      default:      key_ok = 1'b0;
    endcase
  end

  // The synchroniser lags the column by two cycles, so only trust rows late in a slot.
  assign scan_settled = (scan_cnt >= SW'(2));
  assign deb_done     = (deb_cnt == DW'(DEBOUNCE_CYC - 1));
  assign rotate       = (state == SCAN) && (state_nx == SCAN) && (scan_cnt == SW'(SCAN_DIV - 1));
  assign is_term      = (state == ACCEPT) && ((code == 4'hA) || (code == 4'hB));

  always_comb begin
    state_nx = state;
    case (state)
      SCAN: begin
        if (scan_settled && (row_s2 != 4'hF))
          state_nx = armed ? DEBOUNCE : WAIT_RELEASE;
      end
      DEBOUNCE: begin
        if (row_s2 != row_lat)
          state_nx = SCAN;
        else if (deb_done)
          state_nx = key_ok ? ACCEPT : WAIT_RELEASE;
      end
      ACCEPT:
        state_nx = WAIT_RELEASE;
      WAIT_RELEASE: begin
        if ((row_s2 == 4'hF) && deb_done)
          state_nx = SCAN;
      end
      default:
        state_nx = SCAN;
    endcase
  end

  // armed stays low after reset until one idle full rotation or a release, so a key held through reset is not taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SCAN;
      col      <= 4'b1110;
      scan_cnt <= '0;
      deb_cnt  <= '0;
      row_lat  <= 4'hF;
      armed    <= 1'b0;
    end else begin
      state <= state_nx;

      if (state == SCAN && state_nx == SCAN)
        scan_cnt <= rotate ? '0 : scan_cnt + 1'b1;
      else
        scan_cnt <= '0;

      if (rotate) begin
        col <= {col[2:0], col[3]};
        if (col == 4'b0111)
          armed <= 1'b1;
      end

      if (state == WAIT_RELEASE && state_nx == SCAN)
        armed <= 1'b1;

      if (state == SCAN && state_nx != SCAN)
        row_lat <= row_s2;

      if (state_nx != state)
        deb_cnt <= '0;
      else if (state == DEBOUNCE)
        deb_cnt <= deb_cnt + 1'b1;
      else if (state == WAIT_RELEASE)
        deb_cnt <= (row_s2 == 4'hF) ? deb_cnt + 1'b1 : '0;
    end
  end

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idle_cnt <= '0;
    else if (state == ACCEPT || idle_hit)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign idle_hit = (idle_cnt == TW'(TIMEOUT_CYC - 1)) && (state != ACCEPT);
`else
  assign idle_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digitos_value <= '1;
      digitos_valid <= 1'b0;
    end else begin
      digitos_valid <= (state_nx == ACCEPT);
      if (state_nx == ACCEPT)
        digitos_value <= {digitos_value[75:0], code};
      else if (is_term)
        digitos_value <= '1;
      else if (idle_hit && !(&digitos_value))
        digitos_value <= '1;
    end
  end

endmodule

// File: tb/tb_teclado_digitos.sv
// Directed bench for teclado_digitos: keypad model driven from col, buffer expectations derived from the key map.
module tb_teclado_digitos;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [79:0] digitos_value;
  logic        digitos_valid;

  logic        key_down = 1'b0;
  int          key_c = 0;
  logic [3:0]  row_mask = 4'h0;

  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;
  logic [79:0] last_val = '1;
  logic [79:0] after_val = '1;
  logic [79:0] exp_buf = '1;
  logic        valid_d = 1'b0;

  always #5 clk = ~clk;

  assign row = (key_down && (col[key_c] == 1'b0)) ? ~row_mask : 4'hF;

  teclado_digitos #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CYC(8),
    .TIMEOUT_CYC (200)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .row          (row),
    .col          (col),
    .digitos_value(digitos_value),
    .digitos_valid(digitos_valid)
  );

  always @(negedge clk) begin
    if (valid_d) after_val = digitos_value;
    valid_d = digitos_valid;
    if (!rst && digitos_valid) begin
      pulses   = pulses + 1;
      last_val = digitos_value;
    end
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [3:0] code_of(input int r, input int c);
    if (r < 3) return 4'((r * 3) + c + 1);
    if (c == 0) return 4'hA;
    if (c == 1) return 4'h0;
    return 4'hB;
  endfunction

  task automatic press(input int r, input int c, input string tag);
    int p0;
    logic [3:0] code;
    p0       = pulses;
    row_mask = 4'(1 << r);
    key_c    = c;
    key_down = 1'b1;
    for (int i = 0; i < 100 && pulses == p0; i++) @(negedge clk);
    cycles(20);
    check({tag, "_npulse"}, 80'(pulses - p0), 80'd1);
    code    = code_of(r, c);
    exp_buf = {exp_buf[75:0], code};
    check({tag, "_value"}, last_val, exp_buf);
    if (code == 4'hA || code == 4'hB) begin
      check({tag, "_term"}, after_val, '1);
      exp_buf = '1;
    end
    key_down = 1'b0;
    cycles(30);
  endtask

  initial begin
    int p0;
    int d;

    // 1: reset and idle scanning
    rst = 1'b1;
    cycles(3);
    check("rst_col", 80'(col), 80'(4'b1110));
    check("rst_value", digitos_value, '1);
    check("rst_valid", 80'(digitos_valid), 80'd0);
    rst = 1'b0;
    cycles(3);
    check("scan_c0", 80'(col), 80'(4'b1110));
    cycles(1);
    check("scan_c1", 80'(col), 80'(4'b1101));
    cycles(4);
    check("scan_c2", 80'(col), 80'(4'b1011));
    cycles(92);
    check("idle_pulses", 80'(pulses), 80'd0);
    check("idle_value", digitos_value, '1);

    // 2: 1,2,3,4,*
    p0 = pulses;
    press(0, 0, "k1");
    press(0, 1, "k2");
    press(0, 2, "k3");
    press(1, 0, "k4");
    press(3, 0, "kstar");
    check("seq_pulses", 80'(pulses - p0), 80'd5);

    // 3: bounce then hold key 5
    p0       = pulses;
    row_mask = 4'b0010;
    key_c    = 1;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) key_down = ~key_down;
      @(negedge clk);
    end
    key_down = 1'b1;
    for (int i = 0; i < 100 && pulses == p0; i++) @(negedge clk);
    cycles(5);
    check("bounce_npulse", 80'(pulses - p0), 80'd1);
    exp_buf = {exp_buf[75:0], 4'h5};
    check("bounce_value", last_val, exp_buf);
    cycles(500);
    check("hold_npulse", 80'(pulses - p0), 80'd1);
`ifdef KEYPAD_TIMEOUT_EN
    exp_buf = '1;
`endif
    key_down = 1'b0;
    cycles(30);
    press(3, 2, "khash");

    // 4: two rows low, then a letter key
    p0       = pulses;
    row_mask = 4'b0011;
    key_c    = 0;
    key_down = 1'b1;
    cycles(60);
    key_down = 1'b0;
    cycles(30);
    row_mask = 4'b0001;
    key_c    = 3;
    key_down = 1'b1;
    cycles(60);
    key_down = 1'b0;
    cycles(30);
    check("ignored_npulse", 80'(pulses - p0), 80'd0);
    check("ignored_value", digitos_value, exp_buf);

    // 5: overflow with 21 digits
    for (int k = 0; k < 21; k++) begin
      d = (k < 10) ? k : ((k < 20) ? k - 10 : 5);
      if (d == 0) press(3, 1, "ovf");
      else        press((d - 1) / 3, (d - 1) % 3, "ovf");
    end
    check("ovf_d0", 80'(last_val[3:0]), 80'h5);
    check("ovf_d19", 80'(last_val[79:76]), 80'h1);
    press(3, 0, "ovf_clear");

    // 6: idle timeout (or persistence), then reset during debounce
    p0 = pulses;
    press(2, 0, "k7");
    cycles(200);
`ifdef KEYPAD_TIMEOUT_EN
    exp_buf = '1;
`endif
    check("timeout_value", digitos_value, exp_buf);
    check("timeout_npulse", 80'(pulses - p0), 80'd1);

    p0       = pulses;
    row_mask = 4'b0100;
    key_c    = 2;
    key_down = 1'b1;
    for (int i = 0; i < 100 && col != 4'b1011; i++) @(negedge clk);
    check("rst_dbnc_col", 80'(col), 80'(4'b1011));
    cycles(5);
    rst = 1'b1;
    cycles(2);
    check("rst_dbnc_value", digitos_value, '1);
    rst     = 1'b0;
    exp_buf = '1;
    cycles(100);
    check("rst_dbnc_npulse", 80'(pulses - p0), 80'd0);
    key_down = 1'b0;
    cycles(30);
    press(2, 2, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
